// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: datapath widths, ALU op encodings, forward-select
// codes, the ID/EX register payload, and the forward-select helper.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned FWD_W  = 2;

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [ALU_W-1:0]  alu_ctrl_t;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SUB = 3'b010,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_op_e;

  // Code 2'b11 is deliberately left unused.
  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // ID/EX pipeline register contents; all-zero is a harmless bubble (add 0+0).
  typedef struct packed {
    logic      valid;
    logic      reg_write;
    logic      mem_write;
    logic      mem_read;
    logic      alu_src;
    alu_ctrl_t alu_ctrl;
    reg_idx_t  rs1;
    reg_idx_t  rs2;
    reg_idx_t  rd;
    xlen_t     rd1;
    xlen_t     rd2;
    xlen_t     imm;
    xlen_t     pc;
  } id_ex_t;

  // MEM beats WB; x0 is never a forward source.
  function automatic fwd_sel_e fwd_select(input reg_idx_t rs,
                                          input reg_idx_t rd_m, input logic we_m,
                                          input reg_idx_t rd_w, input logic we_w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (we_m && (rd_m != '0) && (rd_m == rs))      sel = FWD_MEM;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of Decode inputs, MEM/WB forward sources, hazard controls and EX outputs.
// master: the surrounding pipeline (drives D/M/W fields, reads E fields)
// slave : ex_operand_stage
interface ex_operand_stage_if;
  import riscv_pkg::*;

  logic      StallE;
  logic      FlushE;
  reg_idx_t  Rs1D;
  reg_idx_t  Rs2D;
  reg_idx_t  RdD;
  xlen_t     RD1D;
  xlen_t     RD2D;
  xlen_t     ImmExtD;
  xlen_t     PCD;
  alu_ctrl_t ALUControlD;
  logic      ALUSrcD;
  logic      RegWriteD;
  logic      MemWriteD;
  logic      MemReadD;

  xlen_t     ALUResultM;
  reg_idx_t  RdM;
  logic      RegWriteM;
  xlen_t     ResultW;
  reg_idx_t  RdW;
  logic      RegWriteW;

  xlen_t     SrcAE;
  xlen_t     SrcBE;
  alu_ctrl_t ALUControlE;
  xlen_t     WriteDataE;
  reg_idx_t  RdE;
  xlen_t     PCE;
  logic      RegWriteE;
  logic      MemWriteE;
  logic      MemReadE;
  logic      ValidE;
  fwd_sel_e  ForwardAE;
  fwd_sel_e  ForwardBE;
  logic      LoadUseHazard;

  modport master (
    output StallE, FlushE, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD,
           ALUControlD, ALUSrcD, RegWriteD, MemWriteD, MemReadD,
           ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    input  SrcAE, SrcBE, ALUControlE, WriteDataE, RdE, PCE, RegWriteE,
           MemWriteE, MemReadE, ValidE, ForwardAE, ForwardBE, LoadUseHazard
  );

  modport slave (
    input  StallE, FlushE, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD,
           ALUControlD, ALUSrcD, RegWriteD, MemWriteD, MemReadD,
           ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    output SrcAE, SrcBE, ALUControlE, WriteDataE, RdE, PCE, RegWriteE,
           MemWriteE, MemReadE, ValidE, ForwardAE, ForwardBE, LoadUseHazard
  );
endinterface

// File: rtl/fwd_unit.sv
// Combinational forward-select generation for both source operands.
// Ports: i_rs1/i_rs2 source indices; i_rd_m/i_reg_write_m MEM writer;
//        i_rd_w/i_reg_write_w WB writer; o_fwd_a_c/o_fwd_b_c selects.
module fwd_unit
  import riscv_pkg::*;
(
  input  reg_idx_t i_rs1,
  input  reg_idx_t i_rs2,
  input  reg_idx_t i_rd_m,
  input  logic     i_reg_write_m,
  input  reg_idx_t i_rd_w,
  input  logic     i_reg_write_w,
  output fwd_sel_e o_fwd_a_c,
  output fwd_sel_e o_fwd_b_c
);

  assign o_fwd_a_c = fwd_select(i_rs1, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
  assign o_fwd_b_c = fwd_select(i_rs2, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding, immediate mux and load-use detect.
// Ports: clk, reset (sync, active-high); bus (slave) carries Decode fields,
//        StallE/FlushE, MEM/WB forward sources and all EX-stage outputs.
// Forwarding and LoadUseHazard are combinational off the registered E fields.
module ex_operand_stage
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ex_operand_stage_if.slave  bus
);

  id_ex_t   r_ex;
  id_ex_t   w_d;
  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;
  xlen_t    w_rs1_val;
  xlen_t    w_rs2_val;

  // Decode fields packed into the next register value.
  always_comb begin
    w_d           = '0;
    w_d.valid     = 1'b1;
    w_d.reg_write = bus.RegWriteD;
    w_d.mem_write = bus.MemWriteD;
    w_d.mem_read  = bus.MemReadD;
    w_d.alu_src   = bus.ALUSrcD;
    w_d.alu_ctrl  = bus.ALUControlD;
    w_d.rs1       = bus.Rs1D;
    w_d.rs2       = bus.Rs2D;
    w_d.rd        = bus.RdD;
    w_d.rd1       = bus.RD1D;
    w_d.rd2       = bus.RD2D;
    w_d.imm       = bus.ImmExtD;
    w_d.pc        = bus.PCD;
  end

  // ID/EX register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset)             r_ex <= '0;
    else if (bus.FlushE)   r_ex <= '0;
    else if (!bus.StallE)  r_ex <= w_d;
  end

  fwd_unit u_fwd (
    .i_rs1         (r_ex.rs1),
    .i_rs2         (r_ex.rs2),
    .i_rd_m        (bus.RdM),
    .i_reg_write_m (bus.RegWriteM),
    .i_rd_w        (bus.RdW),
    .i_reg_write_w (bus.RegWriteW),
    .o_fwd_a_c     (w_fwd_a),
    .o_fwd_b_c     (w_fwd_b)
  );

  // Forwarded operand values.
  always_comb begin
    w_rs1_val = r_ex.rd1;
    w_rs2_val = r_ex.rd2;
    case (w_fwd_a)
      FWD_MEM: w_rs1_val = bus.ALUResultM;
      FWD_WB:  w_rs1_val = bus.ResultW;
      default: w_rs1_val = r_ex.rd1;
    endcase
    case (w_fwd_b)
      FWD_MEM: w_rs2_val = bus.ALUResultM;
      FWD_WB:  w_rs2_val = bus.ResultW;
      default: w_rs2_val = r_ex.rd2;
    endcase
  end

  assign bus.SrcAE       = w_rs1_val;
  assign bus.SrcBE       = r_ex.alu_src ? r_ex.imm : w_rs2_val;
  assign bus.WriteDataE  = w_rs2_val;
  assign bus.ALUControlE = r_ex.alu_ctrl;
  assign bus.RdE         = r_ex.rd;
  assign bus.PCE         = r_ex.pc;
  assign bus.RegWriteE   = r_ex.reg_write;
  assign bus.MemWriteE   = r_ex.mem_write;
  assign bus.MemReadE    = r_ex.mem_read;
  assign bus.ValidE      = r_ex.valid;
  assign bus.ForwardAE   = w_fwd_a;
  assign bus.ForwardBE   = w_fwd_b;

  // Conservative: compares against rs2 even if the D instruction ignores it.
  assign bus.LoadUseHazard = r_ex.mem_read && r_ex.valid && (r_ex.rd != '0) &&
                             ((r_ex.rd == bus.Rs1D) || (r_ex.rd == bus.Rs2D));

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  import riscv_pkg::*;

  logic clk;
  logic reset;
  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string t, input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty, observed=%h", t, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val && e.tag == t)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h (queued tag %s)", t, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_d();
    bus.StallE = 1'b0; bus.FlushE = 1'b0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
    bus.RD1D = '0; bus.RD2D = '0; bus.ImmExtD = '0; bus.PCD = '0;
    bus.ALUControlD = '0; bus.ALUSrcD = 1'b0;
    bus.RegWriteD = 1'b0; bus.MemWriteD = 1'b0; bus.MemReadD = 1'b0;
  endtask

  task automatic clr_mw();
    bus.ALUResultM = '0; bus.RdM = '0; bus.RegWriteM = 1'b0;
    bus.ResultW = '0; bus.RdW = '0; bus.RegWriteW = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clr_d();
    clr_mw();

    // Reset with arbitrary live D inputs -> bubble
    bus.RD1D = 32'hDEAD_BEEF; bus.RD2D = 32'h1234_5678; bus.RdD = 5'd5;
    bus.Rs1D = 5'd5; bus.ALUControlD = ALU_AND; bus.RegWriteD = 1'b1;
    bus.MemReadD = 1'b1; bus.PCD = 32'h100;
    push("rst_valid", 0); push("rst_srca", 0); push("rst_srcb", 0);
    push("rst_aluctl", 0); push("rst_regwr", 0); push("rst_memrd", 0);
    push("rst_pc", 0); push("rst_rd", 0); push("rst_lu", 0);
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(bus.ValidE));
    chk("rst_srca", bus.SrcAE);
    chk("rst_srcb", bus.SrcBE);
    chk("rst_aluctl", 32'(bus.ALUControlE));
    chk("rst_regwr", 32'(bus.RegWriteE));
    chk("rst_memrd", 32'(bus.MemReadE));
    chk("rst_pc", bus.PCE);
    chk("rst_rd", 32'(bus.RdE));
    chk("rst_lu", 32'(bus.LoadUseHazard));

    // First load after reset
    clr_d();
    bus.RD1D = 32'd5; bus.RD2D = 32'd7; bus.Rs1D = 5'd1; bus.Rs2D = 5'd2;
    bus.RdD = 5'd3; bus.ALUControlD = ALU_SUB; bus.PCD = 32'h40; bus.RegWriteD = 1'b1;
    push("ld_srca", 5); push("ld_srcb", 7); push("ld_valid", 1);
    push("ld_aluctl", 32'(ALU_SUB)); push("ld_pc", 32'h40); push("ld_rd", 3);
    step();
    chk("ld_srca", bus.SrcAE);
    chk("ld_srcb", bus.SrcBE);
    chk("ld_valid", 32'(bus.ValidE));
    chk("ld_aluctl", 32'(bus.ALUControlE));
    chk("ld_pc", bus.PCE);
    chk("ld_rd", 32'(bus.RdE));

    // MEM forward to rs1, then disabled, then WB forward
    clr_d();
    bus.Rs1D = 5'd3; bus.RD1D = 32'h11; bus.Rs2D = 5'd8; bus.RD2D = 32'h22;
    step();
    bus.RdM = 5'd3; bus.RegWriteM = 1'b1; bus.ALUResultM = 32'h100;
    push("mem_fa", 32'(FWD_MEM)); push("mem_srca", 32'h100);
    push("mem_fb", 32'(FWD_RF)); push("mem_srcb", 32'h22);
    #1;
    chk("mem_fa", 32'(bus.ForwardAE));
    chk("mem_srca", bus.SrcAE);
    chk("mem_fb", 32'(bus.ForwardBE));
    chk("mem_srcb", bus.SrcBE);
    bus.RegWriteM = 1'b0;
    push("memoff_fa", 32'(FWD_RF)); push("memoff_srca", 32'h11);
    #1;
    chk("memoff_fa", 32'(bus.ForwardAE));
    chk("memoff_srca", bus.SrcAE);
    bus.RdW = 5'd3; bus.RegWriteW = 1'b1; bus.ResultW = 32'h77;
    push("wb_fa", 32'(FWD_WB)); push("wb_srca", 32'h77);
    #1;
    chk("wb_fa", 32'(bus.ForwardAE));
    chk("wb_srca", bus.SrcAE);

    // MEM over WB priority on rs2; x0 never forwarded
    clr_mw();
    clr_d();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd4; bus.RD1D = 32'h33; bus.RD2D = 32'h44;
    step();
    bus.RdM = 5'd4; bus.RdW = 5'd4; bus.RegWriteM = 1'b1; bus.RegWriteW = 1'b1;
    bus.ALUResultM = 32'hA; bus.ResultW = 32'hB;
    push("pri_fb", 32'(FWD_MEM)); push("pri_srcb", 32'hA); push("pri_wdata", 32'hA);
    #1;
    chk("pri_fb", 32'(bus.ForwardBE));
    chk("pri_srcb", bus.SrcBE);
    chk("pri_wdata", bus.WriteDataE);
    bus.RdM = 5'd0;
    push("x0_fa", 32'(FWD_RF)); push("x0_srca", 32'h33);
    push("x0_fb", 32'(FWD_WB)); push("x0_srcb", 32'hB);
    #1;
    chk("x0_fa", 32'(bus.ForwardAE));
    chk("x0_srca", bus.SrcAE);
    chk("x0_fb", 32'(bus.ForwardBE));
    chk("x0_srcb", bus.SrcBE);

    // Immediate selected for SrcB while store data still forwards
    clr_mw();
    clr_d();
    bus.ALUSrcD = 1'b1; bus.ImmExtD = 32'hFFFF_FFFC; bus.Rs2D = 5'd6; bus.RD2D = 32'h66;
    step();
    bus.RdW = 5'd6; bus.RegWriteW = 1'b1; bus.ResultW = 32'h55;
    push("imm_srcb", 32'hFFFF_FFFC); push("imm_wdata", 32'h55); push("imm_fb", 32'(FWD_WB));
    #1;
    chk("imm_srcb", bus.SrcBE);
    chk("imm_wdata", bus.WriteDataE);
    chk("imm_fb", 32'(bus.ForwardBE));

    // Load-use detection
    clr_mw();
    clr_d();
    bus.MemReadD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd9;
    bus.Rs1D = 5'd1; bus.Rs2D = 5'd2;
    push("lu_nomatch", 0);
    step();
    chk("lu_nomatch", 32'(bus.LoadUseHazard));
    bus.Rs2D = 5'd9;
    push("lu_rs2", 1);
    #1;
    chk("lu_rs2", 32'(bus.LoadUseHazard));
    bus.Rs1D = 5'd9; bus.Rs2D = 5'd0;
    push("lu_rs1", 1);
    #1;
    chk("lu_rs1", 32'(bus.LoadUseHazard));
    bus.RdD = 5'd0; bus.Rs1D = 5'd0; bus.Rs2D = 5'd0;
    push("lu_rd0", 0);
    step();
    chk("lu_rd0", 32'(bus.LoadUseHazard));
    bus.RdD = 5'd9; bus.Rs2D = 5'd9;
    push("lu_again", 1);
    step();
    chk("lu_again", 32'(bus.LoadUseHazard));
    bus.FlushE = 1'b1;
    push("fl_valid", 0); push("fl_regwr", 0); push("fl_memrd", 0); push("fl_lu", 0);
    step();
    bus.FlushE = 1'b0;
    chk("fl_valid", 32'(bus.ValidE));
    chk("fl_regwr", 32'(bus.RegWriteE));
    chk("fl_memrd", 32'(bus.MemReadE));
    chk("fl_lu", 32'(bus.LoadUseHazard));

    // Stall holds for 3 cycles under changing D inputs
    clr_d();
    bus.RD1D = 32'h1234; bus.RD2D = 32'h5678; bus.PCD = 32'h80; bus.RdD = 5'd12;
    bus.Rs1D = 5'd10; bus.Rs2D = 5'd11; bus.ALUControlD = ALU_AND; bus.RegWriteD = 1'b1;
    step();
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.RD1D = $urandom; bus.RD2D = $urandom; bus.PCD = $urandom;
      bus.RdD = 5'($urandom_range(1, 31)); bus.ALUControlD = 3'($urandom);
      push("st_srca", 32'h1234); push("st_srcb", 32'h5678); push("st_pc", 32'h80);
      push("st_rd", 12); push("st_aluctl", 32'(ALU_AND)); push("st_valid", 1);
      step();
      chk("st_srca", bus.SrcAE);
      chk("st_srcb", bus.SrcBE);
      chk("st_pc", bus.PCE);
      chk("st_rd", 32'(bus.RdE));
      chk("st_aluctl", 32'(bus.ALUControlE));
      chk("st_valid", 32'(bus.ValidE));
    end
    bus.FlushE = 1'b1;
    push("sf_valid", 0); push("sf_srca", 0); push("sf_pc", 0); push("sf_aluctl", 0);
    step();
    chk("sf_valid", 32'(bus.ValidE));
    chk("sf_srca", bus.SrcAE);
    chk("sf_pc", bus.PCE);
    chk("sf_aluctl", 32'(bus.ALUControlE));

    // Reset mid-operation beats a live load
    clr_d();
    bus.RD1D = 32'h99; bus.RdD = 5'd7; bus.RegWriteD = 1'b1;
    push("rl_valid", 1);
    step();
    chk("rl_valid", 32'(bus.ValidE));
    reset = 1'b1;
    push("rm_valid", 0); push("rm_srca", 0); push("rm_rd", 0);
    step();
    reset = 1'b0;
    chk("rm_valid", 32'(bus.ValidE));
    chk("rm_srca", bus.SrcAE);
    chk("rm_rd", 32'(bus.RdE));

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0 leftover entries", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
